// File: rtl/alarm_pkg.sv
// Types and limits shared between the alarm sequencer and the VGA display stage.
package alarm_pkg;

  typedef enum logic [1:0] {
    STATE_IDLE,
    STATE_SET,
    STATE_TRIGGER,
    STATE_ALERT
  } fsm_state_t;

  localparam int unsigned MAX_COUNTDOWN_S = 99;

endpackage

// File: rtl/input_sync.sv
// Two-flop synchroniser for asynchronous inputs, plus a registered previous value
// so the consumer can detect edges on the synchronised signal.
module input_sync #(
  parameter int unsigned      WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] i_async,
  output logic [WIDTH-1:0] o_sync,
  output logic [WIDTH-1:0] o_prev
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;
  logic [WIDTH-1:0] r_prev;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_meta <= RESET_VAL;
      r_sync <= RESET_VAL;
      r_prev <= RESET_VAL;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign o_sync = r_sync;
  assign o_prev = r_prev;

endmodule

// File: rtl/alarm_controller.sv
// Alarm sequencer: synchronises the panel keys, code switches and sensor, then runs
// the IDLE -> SET -> TRIGGER -> ALERT machine with a whole-second countdown.
module alarm_controller
  import alarm_pkg::*;
#(
  parameter int unsigned CLK_HZ        = 50_000_000,
  parameter int unsigned COUNTDOWN_S   = 30,
  parameter logic [3:0]  DISARM_CODE   = 4'hA,
  parameter int unsigned MAX_BAD_CODES = 3
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       arm_n,
  input  logic       disarm_n,
  input  logic [3:0] code_sw,
  input  logic       sensor,
  output fsm_state_t system_state,
  output logic [7:0] timer,
  output logic       alarm_out
);

  localparam int unsigned PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam int unsigned BW = (MAX_BAD_CODES > 1) ? $clog2(MAX_BAD_CODES + 1) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_HZ - 1);
  localparam logic [BW-1:0] BAD_LAST   = BW'(MAX_BAD_CODES - 1);
  localparam logic [7:0]    TIMER_LOAD = 8'(COUNTDOWN_S);

  if (COUNTDOWN_S < 1 || COUNTDOWN_S > MAX_COUNTDOWN_S) begin : g_bad_countdown
    $error("COUNTDOWN_S must be within 1..%0d", MAX_COUNTDOWN_S);
  end
  if (CLK_HZ < 1 || MAX_BAD_CODES < 1) begin : g_bad_params
    $error("CLK_HZ and MAX_BAD_CODES must be at least 1");
  end

  logic [1:0] w_keys_sync;
  logic [1:0] w_keys_prev;
  logic [3:0] w_code_sync;
  logic [3:0] w_unused_code_prev;
  logic       w_sensor_sync;
  logic       w_unused_sensor_prev;

  // Keys idle high, so they reset to 1 to avoid a spurious press after reset.
  input_sync #(
    .WIDTH    (2),
    .RESET_VAL(2'b11)
  ) u_key_sync (
    .clock  (clock),
    .reset  (reset),
    .i_async({arm_n, disarm_n}),
    .o_sync (w_keys_sync),
    .o_prev (w_keys_prev)
  );

  input_sync #(
    .WIDTH    (4),
    .RESET_VAL(4'h0)
  ) u_code_sync (
    .clock  (clock),
    .reset  (reset),
    .i_async(code_sw),
    .o_sync (w_code_sync),
    .o_prev (w_unused_code_prev)
  );

  input_sync #(
    .WIDTH    (1),
    .RESET_VAL(1'b0)
  ) u_sensor_sync (
    .clock  (clock),
    .reset  (reset),
    .i_async(sensor),
    .o_sync (w_sensor_sync),
    .o_prev (w_unused_sensor_prev)
  );

  logic w_arm_pulse;
  logic w_disarm_pulse;
  logic w_disarm_ok;
  logic w_disarm_bad;
  logic w_tick;

  fsm_state_t    r_state;
  logic [7:0]    r_timer;
  logic          r_alarm;
  logic [PW-1:0] r_presc;
  logic [BW-1:0] r_bad;

  assign w_arm_pulse    = w_keys_prev[1] & ~w_keys_sync[1];
  assign w_disarm_pulse = w_keys_prev[0] & ~w_keys_sync[0];
  assign w_disarm_ok    = w_disarm_pulse && (w_code_sync == DISARM_CODE);
  assign w_disarm_bad   = w_disarm_pulse && (w_code_sync != DISARM_CODE);
  assign w_tick         = (r_presc == PRESC_LAST);

  // Branch order inside TRIGGER encodes: valid disarm > expiry > bad-code limit.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= STATE_IDLE;
      r_timer <= 8'd0;
      r_alarm <= 1'b0;
      r_presc <= '0;
      r_bad   <= '0;
    end else begin
      unique case (r_state)
        STATE_IDLE: begin
          if (w_arm_pulse) begin
            r_state <= STATE_SET;
            r_bad   <= '0;
          end
        end
        STATE_SET: begin
          if (w_disarm_ok) begin
            r_state <= STATE_IDLE;
            r_bad   <= '0;
          end else if (w_sensor_sync) begin
            r_state <= STATE_TRIGGER;
            r_timer <= TIMER_LOAD;
            r_presc <= '0;
          end
        end
        STATE_TRIGGER: begin
          if (w_disarm_ok) begin
            r_state <= STATE_IDLE;
            r_timer <= 8'd0;
            r_presc <= '0;
            r_bad   <= '0;
          end else if (w_tick && r_timer == 8'd1) begin
            r_state <= STATE_ALERT;
            r_timer <= 8'd0;
            r_presc <= '0;
            r_alarm <= 1'b1;
          end else if (w_disarm_bad && r_bad == BAD_LAST) begin
            r_state <= STATE_ALERT;
            r_timer <= 8'd0;
            r_presc <= '0;
            r_alarm <= 1'b1;
          end else begin
            r_presc <= w_tick ? '0 : r_presc + 1'b1;
            if (w_tick) r_timer <= r_timer - 8'd1;
            if (w_disarm_bad) r_bad <= r_bad + 1'b1;
          end
        end
        STATE_ALERT: begin
          if (w_disarm_ok) begin
            r_state <= STATE_IDLE;
            r_alarm <= 1'b0;
            r_bad   <= '0;
          end
        end
        default: begin
          r_state <= STATE_IDLE;
          r_timer <= 8'd0;
          r_alarm <= 1'b0;
        end
      endcase
    end
  end

  assign system_state = r_state;
  assign timer        = r_timer;
  assign alarm_out    = r_alarm;

endmodule

// File: tb/tb_alarm_controller.sv
// Bench for alarm_controller: a cycle-level reference model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_alarm_controller;
  import alarm_pkg::*;

  localparam int unsigned CLK_HZ  = 10;
  localparam int unsigned CD_S    = 3;
  localparam int unsigned MAX_BAD = 3;
  localparam logic [3:0]  CODE    = 4'hA;

  logic       clock    = 1'b0;
  logic       reset    = 1'b1;
  logic       arm_n    = 1'b1;
  logic       disarm_n = 1'b1;
  logic [3:0] code_sw  = 4'h0;
  logic       sensor   = 1'b0;
  fsm_state_t system_state;
  logic [7:0] timer;
  logic       alarm_out;

  alarm_controller #(
    .CLK_HZ       (CLK_HZ),
    .COUNTDOWN_S  (CD_S),
    .DISARM_CODE  (CODE),
    .MAX_BAD_CODES(MAX_BAD)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .arm_n       (arm_n),
    .disarm_n    (disarm_n),
    .code_sw     (code_sw),
    .sensor      (sensor),
    .system_state(system_state),
    .timer       (timer),
    .alarm_out   (alarm_out)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_pass   = 0;
  bit cmp_en   = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
  endtask

  // Reference model: inputs sampled at each edge are seen by the state logic two
  // edges later; the countdown is derived from cycles elapsed since TRIGGER entry.
  fsm_state_t m_state   = STATE_IDLE;
  int         m_elapsed = 0;
  int         m_bad     = 0;
  logic [2:0] h_arm     = 3'b111;  // [0] newest sample
  logic [2:0] h_dis     = 3'b111;
  logic [1:0] h_sen     = 2'b00;
  logic [3:0] h_code0   = 4'h0;
  logic [3:0] h_code1   = 4'h0;

  function automatic int exp_timer();
    if (m_state == STATE_TRIGGER) return int'(CD_S) - m_elapsed / int'(CLK_HZ);
    return 0;
  endfunction

  task automatic model_reset();
    m_state   = STATE_IDLE;
    m_elapsed = 0;
    m_bad     = 0;
    h_arm     = 3'b111;
    h_dis     = 3'b111;
    h_sen     = 2'b00;
    h_code0   = 4'h0;
    h_code1   = 4'h0;
  endtask

  task automatic model_step();
    logic arm_p, dis_p, ok, bad;
    arm_p = h_arm[2] & ~h_arm[1];
    dis_p = h_dis[2] & ~h_dis[1];
    ok    = dis_p && (h_code1 == CODE);
    bad   = dis_p && (h_code1 != CODE);
    case (m_state)
      STATE_IDLE: if (arm_p) begin m_state = STATE_SET; m_bad = 0; end
      STATE_SET: begin
        if (ok) m_state = STATE_IDLE;
        else if (h_sen[1]) begin m_state = STATE_TRIGGER; m_elapsed = 0; end
      end
      STATE_TRIGGER: begin
        m_elapsed++;
        if (ok) begin m_state = STATE_IDLE; m_bad = 0; end
        else if (m_elapsed == int'(CD_S * CLK_HZ)) m_state = STATE_ALERT;
        else if (bad) begin
          m_bad++;
          if (m_bad >= int'(MAX_BAD)) m_state = STATE_ALERT;
        end
      end
      default: if (ok) begin m_state = STATE_IDLE; m_bad = 0; end
    endcase
    h_arm   = {h_arm[1:0], arm_n};
    h_dis   = {h_dis[1:0], disarm_n};
    h_sen   = {h_sen[0], sensor};
    h_code1 = h_code0;
    h_code0 = code_sw;
  endtask

  initial begin
    forever begin
      @(posedge clock or posedge reset);
      if (reset) model_reset();
      else model_step();
    end
  end

  initial begin
    forever begin
      @(negedge clock);
      if (cmp_en) begin
        check("state_vs_model", int'(system_state), int'(m_state));
        check("timer_vs_model", int'(timer), exp_timer());
        check("alarm_vs_model", int'(alarm_out), (m_state == STATE_ALERT) ? 1 : 0);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic expect_out(input string name, input fsm_state_t st, input int tmr,
                            input int alm);
    check({name, "_state"}, int'(system_state), int'(st));
    check({name, "_timer"}, int'(timer), tmr);
    check({name, "_alarm"}, int'(alarm_out), alm);
  endtask

  task automatic arm_to_set();
    arm_n = 1'b0;
    step(3);
    check("arm_to_set", int'(system_state), int'(STATE_SET));
    arm_n = 1'b1;
    step(2);
  endtask

  task automatic sensor_to_trigger();
    sensor = 1'b1;
    step(3);
    expect_out("trigger_entry", STATE_TRIGGER, 3, 0);
    sensor = 1'b0;
  endtask

  int exp_t[3] = '{3, 3, 0};

  initial begin
    @(posedge clock);
    cmp_en = 1'b1;
    step(2);
    reset = 1'b0;
    step(3);
    expect_out("after_reset", STATE_IDLE, 0, 0);

    // Arm latency, then full countdown to ALERT, then valid disarm.
    arm_n = 1'b0;
    step(2);
    check("arm_latency_early", int'(system_state), int'(STATE_IDLE));
    step(1);
    check("arm_latency", int'(system_state), int'(STATE_SET));
    arm_n = 1'b1;
    step(2);
    sensor_to_trigger();
    step(10);
    expect_out("count_2", STATE_TRIGGER, 2, 0);
    step(10);
    expect_out("count_1", STATE_TRIGGER, 1, 0);
    step(9);
    expect_out("pre_alert", STATE_TRIGGER, 1, 0);
    step(1);
    expect_out("alert", STATE_ALERT, 0, 1);
    code_sw  = CODE;
    disarm_n = 1'b0;
    step(3);
    expect_out("alert_disarm", STATE_IDLE, 0, 0);
    disarm_n = 1'b1;
    step(2);

    // Valid disarm mid-countdown.
    arm_to_set();
    sensor_to_trigger();
    step(10);
    expect_out("mid_count", STATE_TRIGGER, 2, 0);
    disarm_n = 1'b0;
    step(2);
    expect_out("disarm_early", STATE_TRIGGER, 2, 0);
    step(1);
    expect_out("trigger_disarm", STATE_IDLE, 0, 0);
    disarm_n = 1'b1;
    step(2);

    // Three wrong codes force ALERT; correct code then returns to IDLE.
    arm_to_set();
    sensor_to_trigger();
    code_sw = 4'h5;
    for (int i = 0; i < 3; i++) begin
      disarm_n = 1'b0;
      step(3);
      expect_out($sformatf("bad_code_%0d", i), (i < 2) ? STATE_TRIGGER : STATE_ALERT,
                 exp_t[i], (i < 2) ? 0 : 1);
      disarm_n = 1'b1;
      step(2);
    end
    code_sw  = CODE;
    disarm_n = 1'b0;
    step(3);
    expect_out("bad_then_good", STATE_IDLE, 0, 0);
    disarm_n = 1'b1;
    step(2);

    // Sensor and valid disarm arrive together in SET: disarm wins.
    arm_to_set();
    sensor   = 1'b1;
    disarm_n = 1'b0;
    step(3);
    expect_out("set_race", STATE_IDLE, 0, 0);
    step(3);
    expect_out("set_race_hold", STATE_IDLE, 0, 0);
    sensor   = 1'b0;
    disarm_n = 1'b1;
    step(2);

    // Asynchronous reset mid-countdown.
    arm_to_set();
    sensor_to_trigger();
    step(10);
    expect_out("pre_reset", STATE_TRIGGER, 2, 0);
    #2 reset = 1'b1;
    #1 expect_out("async_reset", STATE_IDLE, 0, 0);
    step(2);
    reset = 1'b0;
    step(2);

    // Held arm key gives one SET entry; release and re-press gives another.
    arm_n = 1'b0;
    step(3);
    check("held_arm_set", int'(system_state), int'(STATE_SET));
    disarm_n = 1'b0;
    step(3);
    check("held_arm_disarm", int'(system_state), int'(STATE_IDLE));
    disarm_n = 1'b1;
    step(10);
    check("held_arm_no_repeat", int'(system_state), int'(STATE_IDLE));
    arm_n = 1'b1;
    step(2);
    arm_n = 1'b0;
    step(3);
    check("re_press_set", int'(system_state), int'(STATE_SET));
    arm_n = 1'b1;
    step(3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/alarm_controller.md
# alarm_controller

Alarm-system sequencer that owns the system state and the trigger countdown. It debounces-free synchronises the front-panel keys, code switches and motion sensor. It then runs the IDLE → SET → TRIGGER → ALERT state machine and produces a whole-second countdown. It sits directly upstream of the VGA display stage, which consumes `system_state` and `timer` unmodified.

## Interface
Parameters:
- `CLK_HZ`, 50_000_000: input clock frequency; one timer second equals `CLK_HZ` cycles.
- `COUNTDOWN_S`, 30: seconds from trigger to alert; legal range 1..99. An elaboration-time check rejects values outside this range.
- `DISARM_CODE`, 4'hA: value of `code_sw` that makes a disarm press valid.
- `MAX_BAD_CODES`, 3: number of wrong-code disarm presses during TRIGGER that forces ALERT.

Ports:
- `clock`  in  1  system clock, 50 MHz.
- `reset`  in  1  asynchronous, active-high; all state is cleared while high.
- `arm_n`  in  1  arm key, active-low, asynchronous.
- `disarm_n`  in  1  disarm key, active-low, asynchronous.
- `code_sw`  in  4  code switches, asynchronous, sampled when a disarm press is detected.
- `sensor`  in  1  motion sensor, active-high level, asynchronous.
- `system_state`  out  `fsm_state_t`  current state, registered.
- `timer`  out  8  remaining countdown seconds, 0..99, registered, unsigned binary.
- `alarm_out`  out  1  buzzer enable, registered; high only in ALERT.

## Operation
- Synchronisation:
  - All asynchronous inputs pass through two flops.
  - A key press is the falling edge of the synchronised key, which gives a one-cycle pulse.
  - `code_sw` is synchronised the same way.
  - A valid disarm is a disarm pulse with synchronised `code_sw == DISARM_CODE`. An invalid disarm is a disarm pulse with any other code.
- States:
  - IDLE: `timer` = 0. An arm pulse moves to SET.
  - SET: A valid disarm moves to IDLE. Otherwise, synchronised `sensor` high moves to TRIGGER, loads `timer` with `COUNTDOWN_S`, and clears the prescaler.
  - TRIGGER: The prescaler counts 0..`CLK_HZ`-1 and raises a tick at `CLK_HZ`-1. On each tick, `timer` decrements. A tick with `timer == 1` sets `timer` to 0 and moves to ALERT. A valid disarm moves to IDLE with `timer` at 0. Each invalid disarm increments `bad_cnt`; reaching `MAX_BAD_CODES` moves immediately to ALERT with `timer` at 0.
  - ALERT: `timer` is held at 0 and `alarm_out` is 1. A valid disarm moves to IDLE.
- Priority within one cycle: valid disarm beats sensor, beats tick expiry, beats bad-code limit.
- Ignored events:
  - Arm pulses outside IDLE.
  - Sensor activity outside SET.
  - Disarm pulses in IDLE.
  - Invalid disarms outside TRIGGER.
- `bad_cnt` clears on every entry to IDLE or SET. The prescaler runs only in TRIGGER and is held at 0 elsewhere.

## Timing
- Reset values:
  - `system_state` = STATE_IDLE, `timer` = 0, `alarm_out` = 0.
  - The prescaler, `bad_cnt` and all synchroniser flops reset to their idle values; keys reset to 1, sensor to 0.
- Input-to-state latency: an input edge meeting setup before clock edge k appears in `system_state` after edge k+2.
  - Edges k and k+1 are the synchroniser.
  - Edge k+2 is the registered state update with edge detection.
- Countdown timing:
  - The first decrement occurs exactly `CLK_HZ` cycles after the cycle in which `system_state` becomes TRIGGER.
  - ALERT is entered `COUNTDOWN_S`×`CLK_HZ` cycles after TRIGGER entry.
- `alarm_out` changes on the same edge as `system_state`.
- A key held low produces a single pulse; a release followed by a new press produces a new pulse.
- Reset asserted mid-countdown forces IDLE and `timer` = 0 immediately (asynchronous). Operation resumes on the first clock edge after deassertion.

## Structure
- Package `alarm_pkg` holds the following, shared with the display stage:
  - `typedef enum logic [1:0] fsm_state_t {STATE_IDLE, STATE_SET, STATE_TRIGGER, STATE_ALERT}`.
  - Constant `MAX_COUNTDOWN_S = 99`.
- Sub-module `input_sync`, parameterised by width and reset value, contains the two-flop synchroniser plus a registered previous value for edge detection. It is instantiated for the keys, `code_sw` and `sensor`.
- The top level holds the FSM, the prescaler (width $clog2(`CLK_HZ`)), the 8-bit timer and `bad_cnt`.

## Test plan
All scenarios use `CLK_HZ`=10, `COUNTDOWN_S`=3 and `DISARM_CODE`=4'hA.
- Reset asserted, then released with no activity → IDLE, `timer`=0, `alarm_out`=0.
- Arm press, sensor pulse, no disarm → SET, then TRIGGER with `timer`=3. `timer` reads 2, 1, 0 at 10-cycle intervals; ALERT and `alarm_out`=1 arrive 30 cycles after TRIGGER entry.
- In TRIGGER with `timer`=2, disarm with `code_sw`=4'hA → IDLE, `timer`=0 three edges after the press.
- In TRIGGER, three disarm presses with `code_sw`=4'h5 → ALERT on the third press, `timer`=0. A further disarm with 4'hA → IDLE.
- In SET, sensor rise and valid disarm in the same cycle → IDLE, no TRIGGER.
- Reset pulse while `timer`=2 → IDLE and `timer`=0 asynchronously. A held arm key generates exactly one SET entry after release and re-press.
